// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder: stand-in for the RTC chip on the multiplexed A/D bus.
// Latches an address on an address-phase write strobe, writes or reads one of
// six BCD time registers on a data phase, and advances the time on tick_1hz.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   CS, RD, WR        active-low chip select / read / write strobes
//   A_D               bus phase: 0 = address, 1 = data
//   dato_in[7:0]      bus value from the controller
//   tick_1hz          one-cycle pulse, advances time by one second
//   dato_out[7:0]     read data snapshot
//   dato_oe           high while the responder drives the bus
module rtc_bus_responder #(
  parameter logic [7:0] DIR_SEG = 8'h21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CS,
  input  logic       RD,
  input  logic       WR,
  input  logic       A_D,
  input  logic [7:0] dato_in,
  input  logic       tick_1hz,
  output logic [7:0] dato_out,
  output logic       dato_oe
);

  localparam int unsigned DW = 8;
  localparam logic [2:0] IDX_NONE = 3'd7;

  typedef enum logic [1:0] {IDLE, ADDR, WDATA, READ} state_t;

  state_t         state;
  logic [DW-1:0]  dir;
  logic [DW-1:0]  seg, min, hora, dia, mes, anio;
  logic           wr_q;
  logic           tick_pend;
  // Write commit stage: the data strobe edge is captured here and applied a cycle later
  logic           wr_pend;
  logic [2:0]     wr_idx;
  logic [DW-1:0]  wr_data;

  logic           wr_rise;
  logic [DW-1:0]  rd_val;
  logic [DW:0]    seg_inc, min_inc, hora_inc, dia_inc, mes_inc, anio_inc;

  // Map a bus address to a register index; IDX_NONE for non-time addresses
  function automatic logic [2:0] reg_idx(input logic [DW-1:0] a);
    logic [DW-1:0] off;
    off = DW'(a - DIR_SEG);
    if (off < DW'(6)) return off[2:0];
    return IDX_NONE;
  endfunction

  // BCD increment: {carry, next}; wraps to lo at or above hi, repairs bad low nibbles
  function automatic logic [DW:0] bcd_inc(input logic [DW-1:0] v,
                                          input logic [DW-1:0] lo,
                                          input logic [DW-1:0] hi);
    if (v >= hi)              return {1'b1, lo};
    else if (v[3:0] >= 4'd9)  return {1'b0, 4'(v[7:4] + 4'd1), 4'd0};
    else                      return {1'b0, v[7:4], 4'(v[3:0] + 4'd1)};
  endfunction

  assign wr_rise = !wr_q && WR;

  // Carry chain candidates
  always_comb begin
    seg_inc  = bcd_inc(seg,  8'h00, 8'h59);
    min_inc  = bcd_inc(min,  8'h00, 8'h59);
    hora_inc = bcd_inc(hora, 8'h00, 8'h23);
    dia_inc  = bcd_inc(dia,  8'h01, 8'h31);
    mes_inc  = bcd_inc(mes,  8'h01, 8'h12);
    anio_inc = bcd_inc(anio, 8'h00, 8'h99);
  end

  // Read mux for the snapshot taken on READ entry
  always_comb begin
    rd_val = '0;
    case (reg_idx(dir))
      3'd0:    rd_val = seg;
      3'd1:    rd_val = min;
      3'd2:    rd_val = hora;
      3'd3:    rd_val = dia;
      3'd4:    rd_val = mes;
      3'd5:    rd_val = anio;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dir       <= '0;
      seg       <= 8'h00;
      min       <= 8'h00;
      hora      <= 8'h00;
      dia       <= 8'h01;
      mes       <= 8'h01;
      anio      <= 8'h00;
      wr_q      <= 1'b1;
      tick_pend <= 1'b0;
      wr_pend   <= 1'b0;
      wr_idx    <= IDX_NONE;
      wr_data   <= '0;
      dato_out  <= '0;
      dato_oe   <= 1'b0;
    end else begin
      wr_q <= WR;

      // Time registers: a bus write wins over a tick, which then waits one cycle
      if (wr_pend) begin
        wr_pend <= 1'b0;
        case (wr_idx)
          3'd0:    seg  <= wr_data;
          3'd1:    min  <= wr_data;
          3'd2:    hora <= wr_data;
          3'd3:    dia  <= wr_data;
          3'd4:    mes  <= wr_data;
          3'd5:    anio <= wr_data;
          default: ;
        endcase
        tick_pend <= tick_pend | tick_1hz;
      end else if (tick_1hz || tick_pend) begin
        tick_pend <= 1'b0;
        seg <= seg_inc[DW-1:0];
        if (seg_inc[DW]) begin
          min <= min_inc[DW-1:0];
          if (min_inc[DW]) begin
            hora <= hora_inc[DW-1:0];
            if (hora_inc[DW]) begin
              dia <= dia_inc[DW-1:0];
              if (dia_inc[DW]) begin
                mes <= mes_inc[DW-1:0];
                if (mes_inc[DW]) anio <= anio_inc[DW-1:0];
              end
            end
          end
        end
      end

      // Bus protocol
      case (state)
        IDLE: begin
          if (!CS && !(!RD && !WR)) begin
            if (!A_D && !WR) begin
              state <= ADDR;
            end else if (A_D && !WR) begin
              state <= WDATA;
            end else if (A_D && !RD) begin
              state    <= READ;
              dato_out <= rd_val;
              dato_oe  <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (CS) begin
            state <= IDLE;
          end else if (wr_rise) begin
            dir   <= dato_in;
            state <= IDLE;
          end
        end
        WDATA: begin
          if (CS) begin
            state <= IDLE;
          end else if (wr_rise) begin
            wr_pend <= 1'b1;
            wr_idx  <= reg_idx(dir);
            wr_data <= dato_in;
            state   <= IDLE;
          end
        end
        READ: begin
          if (RD || CS) begin
            dato_oe <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// tb_rtc_bus_responder: table-driven write/read vectors plus hand sequences for
// rollover, BCD repair, tick/write collision, reset mid-read and aborts.
// Read data is checked through a scoreboard queue popped on each dato_oe rise.
module tb_rtc_bus_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       CS, RD, WR, A_D;
  logic [7:0] dato_in;
  logic       tick_1hz;
  logic [7:0] dato_out;
  logic       dato_oe;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic       oe_prev = 1'b0;

  always #5 clk = ~clk;

  rtc_bus_responder #(.DIR_SEG(8'h21)) dut (
    .clk(clk), .reset(reset), .CS(CS), .RD(RD), .WR(WR), .A_D(A_D),
    .dato_in(dato_in), .tick_1hz(tick_1hz),
    .dato_out(dato_out), .dato_oe(dato_oe)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every read data phase entry pops one expected value
  always @(negedge clk) begin
    if (dato_oe && !oe_prev) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected_read: got %h expected none", dato_out);
      end else begin
        chk("sb_read", dato_out, exp_q.pop_front());
      end
    end
    oe_prev <= dato_oe;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    CS = 1'b1; RD = 1'b1; WR = 1'b1; A_D = 1'b0;
  endtask

  task automatic write_addr(input logic [7:0] a);
    CS = 1'b0; A_D = 1'b0; WR = 1'b0; dato_in = a;
    step();
    WR = 1'b1;
    step();
    bus_idle();
    step();
  endtask

  task automatic write_data(input logic [7:0] d);
    CS = 1'b0; A_D = 1'b1; WR = 1'b0; dato_in = d;
    step();
    WR = 1'b1;
    step();
    bus_idle();
    step();
    step();
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    write_addr(a);
    write_data(d);
  endtask

  // Read with strobe-to-output-enable timing checks
  task automatic read_reg(input logic [7:0] a, input logic [7:0] exp);
    write_addr(a);
    CS = 1'b0; A_D = 1'b1; RD = 1'b0; WR = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    chk("oe_before_edge", 8'(dato_oe), 8'd0);
    step();
    chk("oe_after_entry", 8'(dato_oe), 8'd1);
    step();
    chk("oe_held", 8'(dato_oe), 8'd1);
    bus_idle();
    step();
    chk("oe_dropped", 8'(dato_oe), 8'd0);
  endtask

  initial begin
    vec_t vecs[8];
    logic [7:0] final_vals[6];
    logic [7:0] roll_exp[6];
    int guard;

    vecs[0] = '{8'h21, 8'h45, 8'h45};
    vecs[1] = '{8'h22, 8'h59, 8'h59};
    vecs[2] = '{8'h23, 8'h17, 8'h17};
    vecs[3] = '{8'h24, 8'h28, 8'h28};
    vecs[4] = '{8'h25, 8'h09, 8'h09};
    vecs[5] = '{8'h26, 8'h77, 8'h77};
    vecs[6] = '{8'h30, 8'h55, 8'h00};
    vecs[7] = '{8'h23, 8'h17, 8'h17};
    final_vals = '{8'h45, 8'h59, 8'h17, 8'h28, 8'h09, 8'h77};
    roll_exp   = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};

    bus_idle();
    dato_in = 8'h00; tick_1hz = 1'b0; reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    chk("reset_oe", 8'(dato_oe), 8'd0);
    chk("reset_dato_out", dato_out, 8'h00);

    read_reg(8'h21, 8'h00);
    read_reg(8'h24, 8'h01);

    // Table: write then read back each vector
    foreach (vecs[i]) begin
      write_reg(vecs[i].addr, vecs[i].data);
      read_reg(vecs[i].addr, vecs[i].exp);
    end
    // Write to 8'h30 must not have touched any time register
    for (int i = 0; i < 6; i++) read_reg(8'(8'h21 + i), final_vals[i]);

    // Full rollover
    write_reg(8'h21, 8'h59); write_reg(8'h22, 8'h59); write_reg(8'h23, 8'h23);
    write_reg(8'h24, 8'h31); write_reg(8'h25, 8'h12); write_reg(8'h26, 8'h99);
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0; step();
    for (int i = 0; i < 6; i++) read_reg(8'(8'h21 + i), roll_exp[i]);

    // Invalid BCD repaired by the increment
    write_reg(8'h21, 8'h3A);
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0; step();
    read_reg(8'h21, 8'h40);

    // Tick on the commit cycle: write wins, increment follows one cycle later
    write_addr(8'h21);
    CS = 1'b0; A_D = 1'b1; WR = 1'b0; dato_in = 8'h10;
    step();
    WR = 1'b1;
    step();
    bus_idle(); tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    chk("collide_write", dut.seg, 8'h10);
    step();
    chk("collide_tick", dut.seg, 8'h11);
    step();
    chk("collide_single", dut.seg, 8'h11);
    read_reg(8'h21, 8'h11);

    // Reset in the middle of a read
    write_reg(8'h23, 8'h17);
    write_addr(8'h23);
    CS = 1'b0; A_D = 1'b1; RD = 1'b0; WR = 1'b1;
    exp_q.push_back(8'h17);
    step();
    chk("midread_oe", 8'(dato_oe), 8'd1);
    reset = 1'b1;
    step();
    chk("reset_midread_oe", 8'(dato_oe), 8'd0);
    chk("reset_midread_hora", dut.hora, 8'h00);
    chk("reset_midread_seg", dut.seg, 8'h00);
    reset = 1'b0; bus_idle();
    step();
    read_reg(8'h23, 8'h00);
    read_reg(8'h24, 8'h01);

    // CS abort during data phase: no write
    write_addr(8'h21);
    CS = 1'b0; A_D = 1'b1; WR = 1'b0; dato_in = 8'h55;
    step();
    CS = 1'b1;
    step();
    WR = 1'b1;
    step(); step();
    read_reg(8'h21, 8'h00);

    // RD and WR low together: ignored
    write_addr(8'h21);
    CS = 1'b0; A_D = 1'b1; RD = 1'b0; WR = 1'b0; dato_in = 8'h99;
    step();
    chk("violation_oe", 8'(dato_oe), 8'd0);
    bus_idle();
    step(); step();
    read_reg(8'h21, 8'h00);

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      step();
      guard++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
